uart_tx: RTL

UART transmitter, the transmit-side counterpart of the team's uart_rx.
- Serialises bytes onto a single idle-high line: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit period is runtime-programmable in clk cycles via clk_div.
- A one-entry holding register, fed by a valid/ready handshake, allows back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes as start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: tx falls one clk after a byte is accepted while idle. A frame lasts div*(10+parity+stop2) clks.
// Backpressure: a one-entry holding register; tx_ready drops while it is full.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clk_div             bit period in clk cycles (0 and 1 act as 2)
//   parity_en/_odd      append parity bit / select odd parity
//   two_stop            two stop bits instead of one
//   tx_din, tx_valid    byte in; tx_ready = holding register empty
//   tx                  registered serial line, idle high
//   tx_busy, tx_done    activity flag, one-cycle end-of-frame pulse
module uart_tx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          clk_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_din,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] hold_reg, hold_d;
  logic [DATA_BITS-1:0] shift_reg, shift_d;
  logic                 hold_full, hold_full_d;
  logic [15:0]          cnt, cnt_d;
  logic [15:0]          sh_div, sh_div_d;
  logic [2:0]           bit_cnt, bit_cnt_d;
  logic                 par_acc, par_d;
  logic                 stop2, stop2_d;
  logic                 sh_pen, sh_pen_d;
  logic                 sh_podd, sh_podd_d;
  logic                 sh_two, sh_two_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 load;

  // sh_div is already clamped to >= 2 when it is captured.
  assign bit_end  = (cnt == sh_div - 16'd1);

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE) || hold_full;

  always_comb begin
    state_d     = state;
    hold_d      = hold_reg;
    hold_full_d = hold_full;
    shift_d     = shift_reg;
    cnt_d       = cnt;
    sh_div_d    = sh_div;
    bit_cnt_d   = bit_cnt;
    par_d       = par_acc;
    stop2_d     = stop2;
    sh_pen_d    = sh_pen;
    sh_podd_d   = sh_podd;
    sh_two_d    = sh_two;
    tx_d        = tx_q;
    done_d      = 1'b0;
    load        = 1'b0;

    if (state != IDLE) begin
      cnt_d = bit_end ? 16'd0 : cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = 16'd0;
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d   = par_acc ^ shift_reg[0];
          shift_d = shift_reg >> 1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = 3'd0;
            if (sh_pen) begin
              state_d = PARITY;
              tx_d    = par_acc ^ shift_reg[0] ^ sh_podd;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              stop2_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            // shift_reg[1] becomes bit 0 after this edge's shift
            tx_d      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          stop2_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (sh_two && !stop2) begin
            stop2_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // A waiting byte starts right away so frames run back to back.
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Start a frame: take the held byte and freeze the line configuration.
    if (load) begin
      state_d     = START;
      shift_d     = hold_reg;
      hold_full_d = 1'b0;
      sh_div_d    = (clk_div < 16'd2) ? 16'd2 : clk_div;
      sh_pen_d    = parity_en;
      sh_podd_d   = parity_odd;
      sh_two_d    = two_stop;
      tx_d        = 1'b0;
      cnt_d       = 16'd0;
      bit_cnt_d   = 3'd0;
      par_d       = 1'b0;
      stop2_d     = 1'b0;
    end

    // load needs hold_full=1 and accept needs hold_full=0, so they never collide.
    if (tx_valid && !hold_full) begin
      hold_d      = tx_din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      cnt       <= 16'd0;
      sh_div    <= 16'd2;
      bit_cnt   <= 3'd0;
      par_acc   <= 1'b0;
      stop2     <= 1'b0;
      sh_pen    <= 1'b0;
      sh_podd   <= 1'b0;
      sh_two    <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      hold_reg  <= hold_d;
      hold_full <= hold_full_d;
      shift_reg <= shift_d;
      cnt       <= cnt_d;
      sh_div    <= sh_div_d;
      bit_cnt   <= bit_cnt_d;
      par_acc   <= par_d;
      stop2     <= stop2_d;
      sh_pen    <= sh_pen_d;
      sh_podd   <= sh_podd_d;
      sh_two    <= sh_two_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule
